apb_gpio_ctrl: RTL and testbench

APB slave GPIO controller, parametrised successor to the fixed 4-bit output-only GPO.
- Per-pin direction, output data and synchronised input readback.
- Per-pin edge-detect interrupts with write-1-to-clear status and a single level irq.
- Sits on the APB bus beside the other peripherals; the tri-state pad buffer lives at chip top, driven by gpio_o / gpio_oe.

---
 rtl/apb_gpio_pkg.sv | 24 ++
 rtl/gpio_edge_detect.sv | 31 +++
 rtl/apb_gpio_ctrl.sv | 105 ++++++++++
 tb/tb_apb_gpio_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_gpio_pkg.sv
// Shared register offsets and word-index encoding for the APB GPIO controller.
package apb_gpio_pkg;

  localparam logic [4:0] ADDR_MODE    = 5'h00;
  localparam logic [4:0] ADDR_ODR     = 5'h04;
  localparam logic [4:0] ADDR_IDR     = 5'h08;
  localparam logic [4:0] ADDR_IER     = 5'h0C;
  localparam logic [4:0] ADDR_EDGE    = 5'h10;
  localparam logic [4:0] ADDR_ISR     = 5'h14;
  localparam logic [4:0] ADDR_ODR_SET = 5'h18;
  localparam logic [4:0] ADDR_ODR_CLR = 5'h1C;

  typedef enum logic [2:0] {
    IDX_MODE    = ADDR_MODE[4:2],
    IDX_ODR     = ADDR_ODR[4:2],
    IDX_IDR     = ADDR_IDR[4:2],
    IDX_IER     = ADDR_IER[4:2],
    IDX_EDGE    = ADDR_EDGE[4:2],
    IDX_ISR     = ADDR_ISR[4:2],
    IDX_ODR_SET = ADDR_ODR_SET[4:2],
    IDX_ODR_CLR = ADDR_ODR_CLR[4:2]
  } reg_idx_e;

endpackage

// File: rtl/gpio_edge_detect.sv
// Pad input synchroniser plus per-pin rising/falling edge detection.
module gpio_edge_detect #(
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [GPIO_W-1:0] pins,
  input  logic [GPIO_W-1:0] edge_cfg,
  output logic [GPIO_W-1:0] sync_val,
  output logic [GPIO_W-1:0] hit
);

  logic [SYNC_STAGES-1:0][GPIO_W-1:0] sync_q;
  logic [GPIO_W-1:0]                  prev;

  // Stage 0 takes the raw pad; the last stage is the metastability-safe value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev   <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pins};
      prev   <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sync_val = sync_q[SYNC_STAGES-1];
  assign hit      = (edge_cfg & ~sync_val & prev) | (~edge_cfg & sync_val & ~prev);

endmodule

// File: rtl/apb_gpio_ctrl.sv
// APB GPIO controller: direction/output/input registers and edge interrupts.
// Optional atomic ODR set/clear registers enabled by defining GPIO_ATOMIC_EN.
module apb_gpio_ctrl #(
  parameter int GPIO_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [4:0]        PADDR,
  input  logic              PWRITE,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  input  logic [GPIO_W-1:0] gpio_i,
  output logic [GPIO_W-1:0] gpio_o,
  output logic [GPIO_W-1:0] gpio_oe,
  output logic              irq
);
  import apb_gpio_pkg::*;

  logic [GPIO_W-1:0] mode, odr, ier, edge_cfg, isr;
  logic [GPIO_W-1:0] sync_val, hit, wdata, w1c;
  logic [31:0]       rdata;
  logic              access, wr, rd;
  reg_idx_e          idx;
  logic              unused_bits;

  assign unused_bits = ^{PADDR[1:0], PWDATA};

  // The !PREADY term makes every transfer commit exactly once.
  assign access = PSEL & PENABLE & ~PREADY;
  assign wr     = access & PWRITE;
  assign rd     = access & ~PWRITE;
  assign idx    = reg_idx_e'(PADDR[4:2]);
  assign wdata  = PWDATA[GPIO_W-1:0];
  assign w1c    = (wr && idx == IDX_ISR) ? wdata : '0;

  function automatic logic [31:0] zext(input logic [GPIO_W-1:0] v);
    zext = '0;
    zext[GPIO_W-1:0] = v;
  endfunction

  always_comb begin
    rdata = '0;
    case (idx)
      IDX_MODE: rdata = zext(mode);
      IDX_ODR:  rdata = zext(odr);
      IDX_IDR:  rdata = zext(sync_val);
      IDX_IER:  rdata = zext(ier);
      IDX_EDGE: rdata = zext(edge_cfg);
      IDX_ISR:  rdata = zext(isr);
      default:  rdata = '0;
    endcase
  end

  gpio_edge_detect #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_edge (
    .clk      (PCLK),
    .rst      (PRESET),
    .pins     (gpio_i),
    .edge_cfg (edge_cfg),
    .sync_val (sync_val),
    .hit      (hit)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      mode     <= '0;
      odr      <= '0;
      ier      <= '0;
      edge_cfg <= '0;
      isr      <= '0;
      PRDATA   <= '0;
      PREADY   <= 1'b0;
      irq      <= 1'b0;
    end else begin
      PREADY <= access;
      irq    <= |(isr & ier);
      // A fresh hit outranks a concurrent clear.
      isr    <= (isr & ~w1c) | hit;
      if (rd) PRDATA <= rdata;
      if (wr) begin
        case (idx)
          IDX_MODE: mode     <= wdata;
          IDX_ODR:  odr      <= wdata;
          IDX_IER:  ier      <= wdata;
          IDX_EDGE: edge_cfg <= wdata;
`ifdef GPIO_ATOMIC_EN
          IDX_ODR_SET: odr <= odr | wdata;
          IDX_ODR_CLR: odr <= odr & ~wdata;
`endif
          default: ;
        endcase
      end
    end
  end

  assign gpio_o  = odr;
  assign gpio_oe = mode;

endmodule

// File: tb/tb_apb_gpio_ctrl.sv
// Scoreboard bench for apb_gpio_ctrl with a register-level reference model.
module tb_apb_gpio_ctrl;
  localparam int GPIO_W = 8;
  localparam int SYNC   = 2;
  localparam logic [31:0] MASK = 32'h0000_00FF;

  logic        PCLK = 1'b0;
  logic        PRESET;
  logic [4:0]  PADDR;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PWDATA, PRDATA;
  logic        PREADY, irq;
  logic [GPIO_W-1:0] gpio_i, gpio_o, gpio_oe;

  always #5 PCLK = ~PCLK;

  apb_gpio_ctrl #(.GPIO_W(GPIO_W), .SYNC_STAGES(SYNC)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_oe(gpio_oe), .irq(irq)
  );

  typedef struct {
    bit          is_rd;
    logic [31:0] exp;
    logic [4:0]  addr;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;

  logic [31:0] m_mode, m_odr, m_ier, m_edge, m_isr, m_pad, last_rd;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    case (a[4:2])
      3'd0: return m_mode;
      3'd1: return m_odr;
      3'd2: return m_pad;
      3'd3: return m_ier;
      3'd4: return m_edge;
      3'd5: return m_isr;
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_write(input logic [4:0] a, input logic [31:0] d);
    case (a[4:2])
      3'd0: m_mode = d & MASK;
      3'd1: m_odr  = d & MASK;
      3'd3: m_ier  = d & MASK;
      3'd4: m_edge = d & MASK;
      3'd5: m_isr  = m_isr & ~d;
`ifdef GPIO_ATOMIC_EN
      3'd6: m_odr  = (m_odr | d) & MASK;
      3'd7: m_odr  = m_odr & ~d;
`endif
      default: ;
    endcase
  endtask

  task automatic model_reset();
    m_mode = 0; m_odr = 0; m_ier = 0; m_edge = 0; m_isr = 0; last_rd = 0;
  endtask

  // Returns #1 after the commit edge, so register effects are already visible.
  task automatic apb(input bit w, input logic [4:0] a, input logic [31:0] d);
    exp_t e;
    bit   seen;
    e.is_rd = !w;
    e.addr  = a;
    if (w) begin
      e.exp = last_rd;
      model_write(a, d);
    end else begin
      e.exp   = model_read(a);
      last_rd = e.exp;
    end
    sb.push_back(e);
    @(posedge PCLK); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = w; PADDR = a; PWDATA = d;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    chk("pready_latency", {31'b0, PREADY}, 32'h1);
    seen = PREADY;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(posedge PCLK); #1;
      seen = PREADY;
    end
    if (!seen) begin
      errors++;
      $display("FAIL pready_timeout actual=0 expected=1");
    end
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic set_pads(input logic [31:0] v);
    logic [31:0] hit;
    @(posedge PCLK); #1;
    gpio_i = v[GPIO_W-1:0];
    hit = ((m_edge & m_pad & ~v) | (~m_edge & ~m_pad & v)) & MASK;
    m_isr = m_isr | hit;
    m_pad = v & MASK;
    repeat (SYNC + 3) @(posedge PCLK);
    #1;
  endtask

  task automatic chk_pins(input string tag);
    @(posedge PCLK); #1;
    chk({tag, "_gpio_o"},  {24'b0, gpio_o},  m_odr);
    chk({tag, "_gpio_oe"}, {24'b0, gpio_oe}, m_mode);
    chk({tag, "_irq"},     {31'b0, irq},     {31'b0, |(m_isr & m_ier)});
  endtask

  // Monitor: each PREADY pulse retires one scoreboard entry.
  initial begin
    bit prev_rdy = 0;
    exp_t e;
    forever begin
      @(negedge PCLK);
      if (PRESET === 1'b1) begin
        prev_rdy = 0;
      end else begin
        if (PREADY === 1'b1) begin
          chk("pready_width", {31'b0, prev_rdy}, 32'h0);
          if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pready actual=1 expected=0");
          end else begin
            e = sb.pop_front();
            chk(e.is_rd ? $sformatf("read_%02h", e.addr) : $sformatf("write_prdata_%02h", e.addr),
                PRDATA, e.exp);
          end
        end
        prev_rdy = (PREADY === 1'b1);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] d;
    logic [4:0]  a;
    PRESET = 1'b1; PSEL = 0; PENABLE = 0; PWRITE = 0; PADDR = 0; PWDATA = 0;
    gpio_i = '0; m_pad = 0;
    model_reset();
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_prdata", PRDATA, 32'h0);
    chk("rst_pready", {31'b0, PREADY}, 32'h0);
    chk("rst_gpio_o", {24'b0, gpio_o}, 32'h0);
    chk("rst_gpio_oe", {24'b0, gpio_oe}, 32'h0);
    chk("rst_irq", {31'b0, irq}, 32'h0);
    PRESET = 1'b0;

    // Reset in the middle of an ODR write: abandoned, nothing committed.
    @(posedge PCLK); #1;
    PSEL = 1; PWRITE = 1; PADDR = 5'h04; PWDATA = 32'hFF;
    @(posedge PCLK); #1;
    PENABLE = 1; PRESET = 1;
    @(posedge PCLK); #1;
    PSEL = 0; PENABLE = 0;
    @(posedge PCLK); #1;
    PRESET = 0;
    chk("midrst_pready", {31'b0, PREADY}, 32'h0);
    chk("midrst_gpio_o", {24'b0, gpio_o}, 32'h0);

    for (int i = 0; i < 8; i++) apb(0, 5'(i * 4), 0);

    apb(1, 5'h00, 32'h0F);
    apb(1, 5'h04, 32'hA5);
    chk("out_gpio_oe", {24'b0, gpio_oe}, 32'h0F);
    chk("out_gpio_o", {24'b0, gpio_o}, 32'hA5);
    apb(0, 5'h04, 0);
    apb(1, 5'h00, 32'hFFFF_FFFF);
    apb(0, 5'h00, 0);

    // Rising edge on pin 0: ISR after SYNC+1 edges, irq one edge later.
    apb(1, 5'h0C, 32'h01);
    apb(1, 5'h10, 32'h00);
    @(posedge PCLK); #1;
    gpio_i[0] = 1'b1;
    m_pad = 32'h1;
    repeat (SYNC + 1) @(posedge PCLK);
    #1;
    chk("irq_not_yet", {31'b0, irq}, 32'h0);
    @(posedge PCLK); #1;
    chk("irq_rise", {31'b0, irq}, 32'h1);
    m_isr = 32'h1;
    apb(0, 5'h14, 0);
    apb(1, 5'h14, 32'h01);
    @(posedge PCLK); #1;
    chk("irq_cleared", {31'b0, irq}, 32'h0);
    apb(0, 5'h14, 0);

    // Falling-edge selection on pin 1.
    apb(1, 5'h10, 32'h02);
    set_pads(m_pad | 32'h2);
    apb(0, 5'h14, 0);
    set_pads(m_pad & ~32'h2);
    apb(0, 5'h14, 0);
    apb(1, 5'h14, 32'h02);
    repeat (6) @(posedge PCLK);
    apb(0, 5'h14, 0);

    // New hit on pin 0 landing on the same edge as its W1C.
    set_pads(m_pad | 32'h1);
    set_pads(m_pad & ~32'h1);
    @(posedge PCLK); #1;
    gpio_i[0] = 1'b1;
    apb(1, 5'h14, 32'h01);
    m_isr = m_isr | 32'h1;
    m_pad = m_pad | 32'h1;
    apb(0, 5'h14, 0);
    chk_pins("collide");
    apb(1, 5'h14, 32'hFF);

    // Atomic set/clear offsets (reserved without the macro).
    apb(1, 5'h04, 32'hF0);
    apb(1, 5'h18, 32'h03);
    apb(0, 5'h04, 0);
    apb(1, 5'h1C, 32'h30);
    apb(0, 5'h04, 0);
    apb(0, 5'h18, 0);
    apb(0, 5'h1C, 0);
    chk_pins("atomic");

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          a = 5'(4 * $urandom_range(0, 7));
          d = $urandom;
          if (a == 5'h14) d = d & 32'h55;
          apb(1, a, d);
        end
        1: apb(0, 5'(4 * $urandom_range(0, 7)), 0);
        2: set_pads($urandom & MASK);
        default: chk_pins("rand");
      endcase
    end
    chk_pins("final");

    repeat (3) @(posedge PCLK);
    #1;
    chk("sb_drained", sb.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
